nco_bcd_scan_disp: RTL and testbench
====================================

NCO_BCD_SCAN_DISP -- requirements
Module: nco_bcd_scan_disp

Interface
REQ-001 Parameter NUM_DIG, 6: number of BCD digits and 7-segment positions, legal range 1..8.
REQ-002 Parameter SCAN_DIV, 5000: clk cycles per digit scan slot, minimum 2.
REQ-003 Parameter DP_POS, 2: digit index whose decimal point is lit; a value >= NUM_DIG means no lit point.
REQ-004 Parameter BLANK_LZ, 1: when 1, leading zero digits are blanked (digit 0 is never blanked).
REQ-005 clk  in  1: single system clock, 50 MHz nominal.
REQ-006 rst_n  in  1: reset, asynchronous, active-low.
REQ-007 i_nco_num  in  32: tick period in clk cycles; 0 disables ticks.
REQ-008 i_run  in  1: 1 = count on ticks, 0 = hold.
REQ-009 i_up  in  1: 1 = count up, 0 = count down.
REQ-010 i_clear  in  1: synchronous clear of count value to 0.
REQ-011 o_seg_enb  out  NUM_DIG: digit enables, active-low, at most one bit low.
REQ-012 o_seg  out  7: segments, active-high; o_seg[6]=a ... o_seg[0]=g.
REQ-013 o_seg_dp  out  1: decimal point, active-high.
REQ-014 o_wrap  out  1: one-cycle pulse on count wrap-around.

Function
REQ-015 The NCO counter shall run 0..i_nco_num-1 and assert an internal tick for one cycle when it equals i_nco_num-1, then return to 0.
REQ-016 A change of i_nco_num to a value at or below the current NCO count shall cause tick plus restart to 0 on the next cycle (no 2^32 run-out).
REQ-017 i_nco_num = 0 shall hold the NCO at 0 with no ticks; i_nco_num = 1 shall tick every cycle.
REQ-018 The NCO shall run regardless of i_run; i_run gates only the BCD counter.
REQ-019 On tick with i_run=1, the BCD counter shall step by 1 in the i_up direction, per-digit carry/borrow across all NUM_DIG digits, in the same cycle.
REQ-020 Up from all-9s shall wrap to all-0s; down from all-0s shall wrap to all-9s; o_wrap shall pulse in the cycle after the wrapping tick.
REQ-021 i_clear shall set the count to 0 on the next edge, with priority over a simultaneous tick; no o_wrap is generated by clear.
REQ-022 A scan divider shall advance digit index 0..NUM_DIG-1 every SCAN_DIV cycles, wrapping to 0.
REQ-023 o_seg_enb, o_seg, and o_seg_dp shall be registered and update together one cycle after the index change; bit k of o_seg_enb shall be low when showing digit k.
REQ-024 o_seg shall encode 0-9 in standard pattern (0 = 7'b1111110, 1 = 7'b0110000, 8 = 7'b1111111); a blanked digit shall output 7'b0000000.
REQ-025 Digit k (k>0) shall be blanked when BLANK_LZ=1 and digits k..NUM_DIG-1 are all 0.
REQ-026 o_seg_dp shall be 1 only while index equals DP_POS.
REQ-027 The displayed value shall be the count sampled at the slot-update edge; mid-slot count changes appear at the next slot.

Reset
REQ-028 While rst_n=0: NCO count 0, BCD count 0, scan divider and index 0, o_seg_enb all ones, o_seg 0, o_seg_dp 0, o_wrap 0.
REQ-029 Assertion mid-operation shall clear all state immediately, independent of clk.
REQ-030 After deassertion, the first tick shall occur i_nco_num cycles later, and the first enable (digit 0) one cycle after the first scan step.

Structure
REQ-031 A shared package (nco_disp_pkg) shall hold the 7-segment encoding constants for 0-9 and blank, plus the BCD digit width constant (4).
REQ-032 The NCO shall be a sub-module nco_tick (clk, rst_n, i_nco_num, o_tick); the counter, scan, and decode logic shall reside in the top.

Verification (NUM_DIG=2, SCAN_DIV=4, DP_POS=1, BLANK_LZ=1 unless stated)
REQ-033 i_nco_num=3, i_run=1, i_up=1 from reset -> ticks every 3 cycles; count 00,01,...,99,00 with a single o_wrap pulse at 99->00.
REQ-034 Count 00, i_up=0, one tick -> count 99, o_wrap pulses once; the display shows 9 on both digits.
REQ-035 Count 05 -> o_seg_enb alternates 2'b10 (o_seg=7'b1011011) and 2'b01 (o_seg=0, o_seg_dp=1), each for 4 cycles.
REQ-036 i_clear together with a tick at count 42 -> count 00 next cycle, no o_wrap; i_run=0 -> count frozen while ticks continue.
REQ-037 i_nco_num changed 1000->2 when the NCO count is 500 -> tick next cycle, then ticks every 2 cycles; i_nco_num=0 -> no ticks.
REQ-038 rst_n pulled low between clk edges mid-count -> all outputs at reset values before the next edge; normal restart after release.

Source files
------------

// File: rtl/nco_disp_pkg.sv
// nco_disp_pkg: shared constants for the NCO-driven BCD counter display.
//   BCD_W       : width of one BCD digit
//   SEG_*       : 7-segment patterns, bit 6 = a ... bit 0 = g, active-high
//   seg_encode  : BCD digit -> segment pattern (non-BCD codes go blank)
package nco_disp_pkg;

  localparam int BCD_W = 4;

  localparam logic [6:0] SEG_0     = 7'b1111110;
  localparam logic [6:0] SEG_1     = 7'b0110000;
  localparam logic [6:0] SEG_2     = 7'b1101101;
  localparam logic [6:0] SEG_3     = 7'b1111001;
  localparam logic [6:0] SEG_4     = 7'b0110011;
  localparam logic [6:0] SEG_5     = 7'b1011011;
  localparam logic [6:0] SEG_6     = 7'b1011111;
  localparam logic [6:0] SEG_7     = 7'b1110000;
  localparam logic [6:0] SEG_8     = 7'b1111111;
  localparam logic [6:0] SEG_9     = 7'b1111011;
  localparam logic [6:0] SEG_BLANK = 7'b0000000;

  function automatic logic [6:0] seg_encode(input logic [BCD_W-1:0] d);
    case (d)
      4'd0:    seg_encode = SEG_0;
      4'd1:    seg_encode = SEG_1;
      4'd2:    seg_encode = SEG_2;
      4'd3:    seg_encode = SEG_3;
      4'd4:    seg_encode = SEG_4;
      4'd5:    seg_encode = SEG_5;
      4'd6:    seg_encode = SEG_6;
      4'd7:    seg_encode = SEG_7;
      4'd8:    seg_encode = SEG_8;
      4'd9:    seg_encode = SEG_9;
      default: seg_encode = SEG_BLANK;
    endcase
  endfunction

endpackage

// File: rtl/nco_tick.sv
// nco_tick: programmable tick generator.
//   clk, rst_n  : clock, async active-low reset
//   i_nco_num   : tick period in clk cycles (0 = no ticks, 1 = every cycle)
//   o_tick      : registered one-cycle tick pulse
// The tick is registered: it is high in the cycle after the counter reaches
// i_nco_num-1, and the counter is already back at 0 in that cycle. From reset
// the first tick is therefore high exactly i_nco_num edges after release.
module nco_tick (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] i_nco_num,
  output logic        o_tick
);

  logic [31:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt    <= '0;
      o_tick <= 1'b0;
    end else if (i_nco_num == '0) begin
      cnt    <= '0;
      o_tick <= 1'b0;
    end else if (cnt >= i_nco_num - 32'd1) begin
      // >= rather than == so a period shrunk below the running count
      // restarts at once instead of running out to 2^32.
      cnt    <= '0;
      o_tick <= 1'b1;
    end else begin
      cnt    <= cnt + 32'd1;
      o_tick <= 1'b0;
    end
  end

endmodule

// File: rtl/nco_bcd_scan_disp.sv
// nco_bcd_scan_disp: NCO-paced BCD up/down counter with a multiplexed
// 7-segment display driver.
//   clk, rst_n  : clock, async active-low reset
//   i_nco_num   : tick period in clk cycles (0 = stopped)
//   i_run       : count on ticks when 1, hold when 0
//   i_up        : count direction (1 = up)
//   i_clear     : synchronous clear of the count, wins over a tick
//   o_seg_enb   : per-digit enables, active-low, one-hot-low while scanning
//   o_seg       : segments a..g on [6:0], active-high
//   o_seg_dp    : decimal point, active-high
//   o_wrap      : one-cycle pulse after a tick that wrapped the count
module nco_bcd_scan_disp
  import nco_disp_pkg::*;
#(
  parameter int NUM_DIG  = 6,
  parameter int SCAN_DIV = 5000,
  parameter int DP_POS   = 2,
  parameter int BLANK_LZ = 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [31:0]        i_nco_num,
  input  logic               i_run,
  input  logic               i_up,
  input  logic               i_clear,
  output logic [NUM_DIG-1:0] o_seg_enb,
  output logic [6:0]         o_seg,
  output logic               o_seg_dp,
  output logic               o_wrap
);

  localparam int IDX_W = (NUM_DIG > 1) ? $clog2(NUM_DIG) : 1;
  localparam int DIV_W = $clog2(SCAN_DIV);

  logic tick;

  nco_tick u_nco (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_nco_num (i_nco_num),
    .o_tick    (tick)
  );

  // ---------------------------------------------------------------- counter
  logic [NUM_DIG-1:0][BCD_W-1:0] bcd, bcd_nxt;
  logic                          wrap_nxt;

  // Ripple carry (up) / borrow (down) through all digits; a carry out of
  // the top digit means every digit sat at its terminal value, i.e. a wrap.
  always_comb begin
    logic c;
    c        = 1'b1;
    bcd_nxt  = bcd;
    for (int k = 0; k < NUM_DIG; k++) begin
      if (c) begin
        if (i_up) begin
          bcd_nxt[k] = (bcd[k] == 4'd9) ? 4'd0 : bcd[k] + 4'd1;
          c          = (bcd[k] == 4'd9);
        end else begin
          bcd_nxt[k] = (bcd[k] == 4'd0) ? 4'd9 : bcd[k] - 4'd1;
          c          = (bcd[k] == 4'd0);
        end
      end
    end
    wrap_nxt = c;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bcd    <= '0;
      o_wrap <= 1'b0;
    end else begin
      o_wrap <= 1'b0;
      if (i_clear) begin
        bcd <= '0;
      end else if (tick && i_run) begin
        bcd    <= bcd_nxt;
        o_wrap <= wrap_nxt;
      end
    end
  end

  // ------------------------------------------------------------------- scan
  logic [DIV_W-1:0] div;
  logic [IDX_W-1:0] idx;
  logic             active;  // first slot shows digit 0 rather than advancing
  logic             load;    // one cycle after each slot step
  logic             slot;

  assign slot = (div == DIV_W'(SCAN_DIV - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div    <= '0;
      idx    <= '0;
      active <= 1'b0;
      load   <= 1'b0;
    end else begin
      load <= slot;
      if (slot) begin
        div    <= '0;
        active <= 1'b1;
        if (active)
          idx <= (idx == IDX_W'(NUM_DIG - 1)) ? '0 : idx + IDX_W'(1);
      end else begin
        div <= div + DIV_W'(1);
      end
    end
  end

  // ----------------------------------------------------------------- decode
  logic [NUM_DIG-1:0] blank;
  logic [BCD_W-1:0]   dig;
  logic               dig_blank;

  // Digit k blanks when it and every digit above it are zero; digit 0 never.
  always_comb begin
    logic z;
    z     = 1'b1;
    blank = '0;
    for (int k = NUM_DIG - 1; k > 0; k--) begin
      z        = z & (bcd[k] == 4'd0);
      blank[k] = (BLANK_LZ != 0) & z;
    end
  end

  always_comb begin
    dig       = '0;
    dig_blank = 1'b0;
    for (int k = 0; k < NUM_DIG; k++) begin
      if (idx == IDX_W'(k)) begin
        dig       = bcd[k];
        dig_blank = blank[k];
      end
    end
  end

  // Display registers load only at slot updates so a digit holds the value
  // captured at the start of its slot.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      o_seg_enb <= '1;
      o_seg     <= SEG_BLANK;
      o_seg_dp  <= 1'b0;
    end else if (load) begin
      o_seg_enb <= ~(NUM_DIG'(1) << idx);
      o_seg     <= dig_blank ? SEG_BLANK : seg_encode(dig);
      o_seg_dp  <= (int'(idx) == DP_POS);
    end
  end

endmodule

// File: tb/tb_nco_bcd_scan_disp.sv
// tb_nco_bcd_scan_disp: directed bench for nco_bcd_scan_disp with
// NUM_DIG=2, SCAN_DIV=4, DP_POS=1, BLANK_LZ=1. Expected values are
// hand-derived cycle counts from reset release or from a stimulus change.
module tb_nco_bcd_scan_disp;

  localparam int NUM_DIG  = 2;
  localparam int SCAN_DIV = 4;
  localparam int DP_POS   = 1;
  localparam int BLANK_LZ = 1;

  logic               clk = 1'b0;
  logic               rst_n;
  logic [31:0]        i_nco_num;
  logic               i_run, i_up, i_clear;
  logic [NUM_DIG-1:0] o_seg_enb;
  logic [6:0]         o_seg;
  logic               o_seg_dp, o_wrap;

  int checks = 0, errors = 0, n = 0, wrap_cnt = 0, tick_seen = 0;

  nco_bcd_scan_disp #(
    .NUM_DIG (NUM_DIG), .SCAN_DIV(SCAN_DIV), .DP_POS(DP_POS), .BLANK_LZ(BLANK_LZ)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_nco_num (i_nco_num),
    .i_run     (i_run),
    .i_up      (i_up),
    .i_clear   (i_clear),
    .o_seg_enb (o_seg_enb),
    .o_seg     (o_seg),
    .o_seg_dp  (o_seg_dp),
    .o_wrap    (o_wrap)
  );

  always #5 clk = ~clk;

  logic [7:0]  cnt_obs;
  logic        tick_obs;
  logic [31:0] nco_obs;
  assign cnt_obs  = dut.bcd;
  assign tick_obs = dut.u_nco.o_tick;
  assign nco_obs  = dut.u_nco.cnt;

  always @(posedge clk) begin
    #1;
    if (o_wrap === 1'b1) wrap_cnt++;
  end

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
    n++;
  endtask

  task automatic wait_enb(input logic [NUM_DIG-1:0] v);
    int k = 0;
    while (o_seg_enb !== v && k < 40) begin step(); k++; end
    if (o_seg_enb !== v) chk("wait_enb_timeout", o_seg_enb, v);
  endtask

  task automatic wait_cnt(input logic [7:0] v, input int lim);
    int k = 0;
    while (cnt_obs !== v && k < lim) begin step(); k++; end
    if (cnt_obs !== v) chk("wait_cnt_timeout", cnt_obs, v);
  endtask

  function automatic logic [7:0] to_bcd(input int v);
    to_bcd = {4'(v / 10), 4'(v % 10)};
  endfunction

  // Release reset at a negedge and check tick / first display timing.
  task automatic restart_checks(input string p);
    rst_n = 1'b1;
    n = 0;
    step(); step();
    chk({p, "_tick_early"}, tick_obs, 1'b0);
    step();
    chk({p, "_first_tick"}, tick_obs, 1'b1);
    step();
    chk({p, "_cnt_01"}, cnt_obs, 8'h01);
    chk({p, "_enb_idle"}, o_seg_enb, 2'b11);
    step();
    chk({p, "_first_enb"}, o_seg_enb, 2'b10);
    chk({p, "_first_seg"}, o_seg, 7'b0110000);
    chk({p, "_first_dp"}, o_seg_dp, 1'b0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; i_nco_num = 32'd3; i_run = 1'b1; i_up = 1'b1; i_clear = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_enb", o_seg_enb, 2'b11);
    chk("rst_seg", o_seg, 7'b0);
    chk("rst_dp", o_seg_dp, 1'b0);
    chk("rst_wrap", o_wrap, 1'b0);
    chk("rst_cnt", cnt_obs, 8'h00);

    // Count up, period 3: count m+1 after edge 4+3m, one wrap at 99->00.
    restart_checks("init");
    for (int m = 1; m <= 99; m++) begin
      while (n < 4 + 3 * m) step();
      chk("up_seq", cnt_obs, to_bcd((m + 1) % 100));
    end
    step(); step();
    chk("wrap_once", wrap_cnt, 1);

    // Down from 00: next tick lands at edge 304.
    i_up = 1'b0;
    step();
    chk("down_wrap_cnt", cnt_obs, 8'h99);
    step();
    chk("down_wrap_pulse", wrap_cnt, 2);
    i_run = 1'b0;
    wait_enb(2'b01);
    wait_enb(2'b10);
    chk("disp99_d0", o_seg, 7'b1111011);
    wait_enb(2'b01);
    chk("disp99_d1", o_seg, 7'b1111011);
    chk("disp99_dp", o_seg_dp, 1'b1);

    // Count 05: digit 0 shows 5, digit 1 blanked with the point lit.
    i_clear = 1'b1;
    step();
    i_clear = 1'b0;
    chk("clear_cnt", cnt_obs, 8'h00);
    i_up = 1'b1; i_run = 1'b1;
    wait_cnt(8'h05, 40);
    i_run = 1'b0;
    wait_enb(2'b01);
    wait_enb(2'b10);
    for (int i = 0; i < 4; i++) begin
      chk("d0_enb", o_seg_enb, 2'b10);
      chk("d0_seg5", o_seg, 7'b1011011);
      chk("d0_dp", o_seg_dp, 1'b0);
      step();
    end
    for (int i = 0; i < 4; i++) begin
      chk("d1_enb", o_seg_enb, 2'b01);
      chk("d1_blank", o_seg, 7'b0);
      chk("d1_dp", o_seg_dp, 1'b1);
      step();
    end

    // Clear colliding with a tick at 42; then freeze with ticks running.
    i_nco_num = 32'd1; i_run = 1'b1;
    wait_cnt(8'h42, 200);
    chk("tick_at_42", tick_obs, 1'b1);
    i_clear = 1'b1;
    step();
    i_clear = 1'b0;
    chk("clear_beats_tick", cnt_obs, 8'h00);
    chk("clear_no_wrap", o_wrap, 1'b0);
    repeat (3) step();
    chk("run_three", cnt_obs, 8'h03);
    i_run = 1'b0;
    repeat (10) step();
    chk("frozen", cnt_obs, 8'h03);
    chk("ticks_while_frozen", tick_obs, 1'b1);

    // Period shrink 1000 -> 2 at NCO count 500.
    i_nco_num = 32'd1000;
    begin
      int k = 0;
      while (nco_obs !== 32'd500 && k < 1200) begin step(); k++; end
    end
    chk("nco_at_500", nco_obs, 32'd500);
    chk("no_tick_500", tick_obs, 1'b0);
    i_nco_num = 32'd2;
    step();
    chk("shrink_tick", tick_obs, 1'b1);
    chk("shrink_restart", nco_obs, 32'd0);
    step(); chk("p2_low", tick_obs, 1'b0);
    step(); chk("p2_high", tick_obs, 1'b1);
    step(); chk("p2_low2", tick_obs, 1'b0);
    i_nco_num = 32'd0;
    tick_seen = 0;
    repeat (10) begin
      step();
      if (tick_obs) tick_seen++;
    end
    chk("nco0_no_ticks", tick_seen, 0);

    // From NCO idle at period 3: count 03 -> 09 over 20 edges.
    i_nco_num = 32'd3; i_run = 1'b1;
    repeat (20) step();
    chk("pre_reset_cnt", cnt_obs, 8'h09);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("async_enb", o_seg_enb, 2'b11);
    chk("async_seg", o_seg, 7'b0);
    chk("async_dp", o_seg_dp, 1'b0);
    chk("async_wrap", o_wrap, 1'b0);
    chk("async_cnt", cnt_obs, 8'h00);
    chk("async_nco", nco_obs, 32'd0);
    @(negedge clk);
    step();
    restart_checks("rerun");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
